turn_switch_conditioner: RTL and testbench

- Upstream input stage for the turn-signal controller. Runs on the divided clock (Clk) that also drives the turn-signal sequencer.
- Takes the raw, asynchronous hazard/left/right switch levels. Synchronises and debounces each one, and resolves a conflicting left+right request.
- Emits clean E/L/R levels plus a change pulse, ready to feed the sequencer's E, L and R inputs directly.

---
 rtl/turn_switch_conditioner_pkg.sv | 16 +
 rtl/turn_switch_conditioner_if.sv | 26 ++
 rtl/turn_switch_conditioner_debounce.sv | 50 +++++
 rtl/turn_switch_conditioner.sv | 100 ++++++++++
 tb/tb_turn_switch_conditioner.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/turn_switch_conditioner_pkg.sv
// turn_signal_pkg: definitions shared by the turn-switch conditioner and its
// debounce sub-module.
//   - arb_state_t         : 2-bit arbitration state encoding (IDLE/LEFT/RIGHT/CONFLICT)
//   - DEBOUNCE_CYCLES_DEF : default debounce length, in Clk cycles
package turn_signal_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEFT     = 2'd1,
        ST_RIGHT    = 2'd2,
        ST_CONFLICT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/turn_switch_conditioner_if.sv
// turn_switch_conditioner_if: raw switch levels in, conditioned levels out.
//   ERaw/LRaw/RRaw : raw hazard/left/right switches, asynchronous to Clk
//   E/L/R          : conditioned hazard level, left and right requests
//   Conflict       : left and right both debounced-active and unresolved
//   SwChange       : one-cycle pulse after any of E/L/R changes
// master = switch/stimulus side, slave = conditioner side.
interface turn_switch_conditioner_if;
    logic ERaw;
    logic LRaw;
    logic RRaw;
    logic E;
    logic L;
    logic R;
    logic Conflict;
    logic SwChange;

    modport master (
        output ERaw, LRaw, RRaw,
        input  E, L, R, Conflict, SwChange
    );

    modport slave (
        input  ERaw, LRaw, RRaw,
        output E, L, R, Conflict, SwChange
    );
endinterface

// File: rtl/turn_switch_conditioner_debounce.sv
// switch_debounce: two-flop synchroniser plus counter debounce for one switch.
//   Clk   : clock, rising edge
//   Rst   : synchronous active-high reset
//   Raw   : raw switch level, asynchronous to Clk
//   Level : debounced level; follows the synchronised input once it has
//           differed for DEBOUNCE_CYCLES consecutive cycles
module switch_debounce
    import turn_signal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Raw,
    output logic Level
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          s;
    logic          d;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            d     <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= Raw;
            s     <= sync1;
            // cnt only advances while s disagrees with d and is cleared on
            // the update, so it never passes CNT_LAST and cannot wrap.
            if (s == d) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                d   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign Level = d;

endmodule

// File: rtl/turn_switch_conditioner.sv
// turn_switch_conditioner: input stage for the turn-signal sequencer.
// Debounces the hazard/left/right switches, arbitrates left vs right on a
// first-come basis, and flags changes of the conditioned outputs.
//   Clk : divided system clock, rising edge
//   Rst : synchronous active-high reset
//   sw  : slave modport of turn_switch_conditioner_if (raw in, E/L/R/Conflict/SwChange out)
module turn_switch_conditioner
    import turn_signal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                         Clk,
    input  logic                         Rst,
    turn_switch_conditioner_if.slave     sw
);

    logic       de, dl, dr;
    arb_state_t state, state_nxt;
    logic       e_q;
    logic       l_o, r_o, c_o;
    logic [2:0] outs_prev;
    logic       swchg_q;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_e (
        .Clk(Clk), .Rst(Rst), .Raw(sw.ERaw), .Level(de)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .Clk(Clk), .Rst(Rst), .Raw(sw.LRaw), .Level(dl)
    );
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .Clk(Clk), .Rst(Rst), .Raw(sw.RRaw), .Level(dr)
    );

    // Arbitration state register
    always_ff @(posedge Clk) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: the side that got there first keeps ownership; a late
    // request on the other side is only served once the owner releases.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if      (dl && dr) state_nxt = ST_CONFLICT;
                else if (dl)       state_nxt = ST_LEFT;
                else if (dr)       state_nxt = ST_RIGHT;
            end
            ST_LEFT: begin
                if (!dl) state_nxt = dr ? ST_RIGHT : ST_IDLE;
            end
            ST_RIGHT: begin
                if (!dr) state_nxt = dl ? ST_LEFT : ST_IDLE;
            end
            ST_CONFLICT: begin
                if      (dl && dr) state_nxt = ST_CONFLICT;
                else if (dl)       state_nxt = ST_LEFT;
                else if (dr)       state_nxt = ST_RIGHT;
                else               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        l_o = 1'b0;
        r_o = 1'b0;
        c_o = 1'b0;
        case (state)
            ST_LEFT:     l_o = 1'b1;
            ST_RIGHT:    r_o = 1'b1;
            ST_CONFLICT: c_o = 1'b1;
            default:     ;
        endcase
    end

    // E goes through one register so it lines up with the state-decoded L/R.
    // SwChange compares E/L/R with their value one cycle earlier; clearing
    // outs_prev together with the outputs keeps reset from producing a pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            e_q       <= 1'b0;
            outs_prev <= 3'b000;
            swchg_q   <= 1'b0;
        end else begin
            e_q       <= de;
            outs_prev <= {e_q, l_o, r_o};
            swchg_q   <= ({e_q, l_o, r_o} != outs_prev);
        end
    end

    assign sw.E        = e_q;
    assign sw.L        = l_o;
    assign sw.R        = r_o;
    assign sw.Conflict = c_o;
    assign sw.SwChange = swchg_q;

endmodule

// File: tb/tb_turn_switch_conditioner.sv
// Directed bench for turn_switch_conditioner with the default debounce of 4.
// Raw inputs are changed 1 time unit after a rising edge; that next rising
// edge is counted as k=0, so E/L/R are expected to move after edge k=6 and
// SwChange to be high only after edge k=7.
module tb_turn_switch_conditioner;

    logic Clk = 1'b0;
    logic Rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    turn_switch_conditioner_if sw ();

    turn_switch_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .sw (sw.slave)
    );

    always #5 Clk = ~Clk;

    // {E, L, R, Conflict}
    wire [3:0] o = {sw.E, sw.L, sw.R, sw.Conflict};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        sw.ERaw = 1'b0;
        sw.LRaw = 1'b0;
        sw.RRaw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        logic [3:0] exp_o;
        logic       exp_sw;
        Rst = 1'b1;
        sw.ERaw = 1'b1;
        sw.LRaw = 1'b1;
        sw.RRaw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({o, sw.SwChange} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d: got %b want 00000", k, {o, sw.SwChange});
            end
        end
        Rst = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_o  = (k >= 6) ? 4'b1001 : 4'b0000;
            exp_sw = (k == 7);
            n_checks++;
            if (o !== exp_o || sw.SwChange !== exp_sw) begin
                n_fail++;
                $display("FAIL reset_release k=%0d: got %b/%b want %b/%b",
                         k, o, sw.SwChange, exp_o, exp_sw);
            end
        end
        settle();
    endtask

    task automatic test_clean_left();
        logic [3:0] exp_o;
        logic       exp_sw;
        sw.LRaw = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_o  = (k >= 6) ? 4'b0100 : 4'b0000;
            exp_sw = (k == 7);
            n_checks++;
            if (o !== exp_o || sw.SwChange !== exp_sw) begin
                n_fail++;
                $display("FAIL left_rise k=%0d: got %b/%b want %b/%b",
                         k, o, sw.SwChange, exp_o, exp_sw);
            end
        end
        sw.LRaw = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_o  = (k >= 6) ? 4'b0000 : 4'b0100;
            exp_sw = (k == 7);
            n_checks++;
            if (o !== exp_o || sw.SwChange !== exp_sw) begin
                n_fail++;
                $display("FAIL left_fall k=%0d: got %b/%b want %b/%b",
                         k, o, sw.SwChange, exp_o, exp_sw);
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        // 3 cycles high: must be discarded
        sw.LRaw = 1'b1;
        repeat (3) tick();
        sw.LRaw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (sw.L !== 1'b0 || sw.SwChange !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch3 k=%0d: got L=%b sw=%b want L=0 sw=0", k, sw.L, sw.SwChange);
            end
        end
        // exactly 4 cycles high: must propagate
        sw.LRaw = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (k == 3) sw.LRaw = 1'b0;
            if (k >= 5) begin
                n_checks++;
                if (sw.L !== (k == 6)) begin
                    n_fail++;
                    $display("FAIL glitch4 k=%0d: got L=%b want %b", k, sw.L, (k == 6));
                end
            end
        end
        settle();
    endtask

    task automatic test_priority();
        logic [3:0] exp_o;
        logic       exp_sw;
        sw.LRaw = 1'b1;
        repeat (9) tick();
        sw.RRaw = 1'b1;
        repeat (9) tick();
        n_checks++;
        if (o !== 4'b0100 || sw.SwChange !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_hold: got %b/%b want 0100/0", o, sw.SwChange);
        end
        sw.LRaw = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_o  = (k >= 6) ? 4'b0010 : 4'b0100;
            exp_sw = (k == 7);
            n_checks++;
            if (o !== exp_o || sw.SwChange !== exp_sw) begin
                n_fail++;
                $display("FAIL prio_handover k=%0d: got %b/%b want %b/%b",
                         k, o, sw.SwChange, exp_o, exp_sw);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_o;
        sw.LRaw = 1'b1;
        sw.RRaw = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            exp_o = (k >= 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            // Conflict alone never pulses SwChange
            if (o !== exp_o || sw.SwChange !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_rise k=%0d: got %b/%b want %b/0", k, o, sw.SwChange, exp_o);
            end
        end
        sw.RRaw = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            exp_o = (k >= 6) ? 4'b0100 : 4'b0001;
            n_checks++;
            if (o !== exp_o || sw.SwChange !== (k == 7)) begin
                n_fail++;
                $display("FAIL simul_resolve k=%0d: got %b/%b want %b/%b",
                         k, o, sw.SwChange, exp_o, (k == 7));
            end
        end
        settle();
    endtask

    task automatic test_multi_change();
        // E and L change on the same edge: one single pulse
        sw.ERaw = 1'b1;
        sw.LRaw = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (k >= 5) begin
                n_checks++;
                if (o !== ((k >= 6) ? 4'b1100 : 4'b0000) || sw.SwChange !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL multi_change k=%0d: got %b/%b want %b/%b", k, o, sw.SwChange,
                             ((k >= 6) ? 4'b1100 : 4'b0000), (k == 7));
                end
            end
        end
        settle();
    endtask

    task automatic test_mid_reset();
        sw.ERaw = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (sw.E !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got E=%b want 1", sw.E);
        end
        Rst = 1'b1;
        tick();
        n_checks++;
        if (o !== 4'b0000 || sw.SwChange !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_edge: got %b/%b want 0000/0", o, sw.SwChange);
        end
        Rst = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            n_checks++;
            if (sw.E !== (k >= 6) || sw.SwChange !== (k == 7)) begin
                n_fail++;
                $display("FAIL midrst_recover k=%0d: got E=%b sw=%b want E=%b sw=%b",
                         k, sw.E, sw.SwChange, (k >= 6), (k == 7));
            end
        end
        settle();
    endtask

    initial begin
        Rst     = 1'b1;
        sw.ERaw = 1'b0;
        sw.LRaw = 1'b0;
        sw.RRaw = 1'b0;
        test_reset();
        test_clean_left();
        test_glitch();
        test_priority();
        test_simultaneous();
        test_multi_change();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
